// File: rtl/csd_convert_array_pkg.sv
// Shared types for the binary->CSD converter array: FSM states, digit
// encoding and the single-step recoding rule.
package csd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CONV  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef logic [1:0] digit_t;

  localparam digit_t DIG_ZERO = 2'b00;
  localparam digit_t DIG_POS  = 2'b01;
  localparam digit_t DIG_NEG  = 2'b10;

  typedef struct packed {
    digit_t d;
    logic   c;
  } step_t;

  // One CSD recoding step on x = b_i + c_in, looking ahead at b_next.
  function automatic step_t recode_step(input logic b_i, input logic b_next,
                                        input logic c_in);
    step_t r;
    r.d = DIG_ZERO;
    r.c = 1'b0;
    unique case ({b_i, c_in})
      2'b00: begin r.d = DIG_ZERO; r.c = 1'b0; end
      2'b11: begin r.d = DIG_ZERO; r.c = 1'b1; end
      default: begin
        // x == 1: start or extend a run of ones with -1, else emit a lone +1
        if (b_next) begin r.d = DIG_NEG; r.c = 1'b1; end
        else        begin r.d = DIG_POS; r.c = 1'b0; end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csd_convert_array_if.sv
// Host-side bus of the converter array: operand write, batch control,
// result read-back and status.
interface csd_convert_array_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 2);

  logic            we_in;
  logic [AW-1:0]   addr_in;
  logic [WIDTH-1:0] data_in;
  logic            start;
  logic [AW:0]     n_words;
  logic [AW-1:0]   rd_addr;
  logic [WIDTH:0]  rd_pos;
  logic [WIDTH:0]  rd_neg;
  logic [CW-1:0]   rd_cnt;
  logic            busy;
  logic            done;

  modport master (
    output we_in, addr_in, data_in, start, n_words, rd_addr,
    input  rd_pos, rd_neg, rd_cnt, busy, done
  );

  modport slave (
    input  we_in, addr_in, data_in, start, n_words, rd_addr,
    output rd_pos, rd_neg, rd_cnt, busy, done
  );
endinterface

// File: rtl/csd_convert_array_recode_step.sv
// Combinational single-digit CSD recoder used by the serial CONV datapath.
module csd_recode_step
  import csd_pkg::*;
(
  input  logic   b_i,
  input  logic   b_next,
  input  logic   c_in,
  output digit_t d,
  output logic   c_out
);
  step_t s;

  assign s     = recode_step(b_i, b_next, c_in);
  assign d     = s.d;
  assign c_out = s.c;
endmodule

// File: rtl/csd_convert_array.sv
// Batch binary->CSD converter. Operands are loaded into an operand RAM,
// a start pulse converts words 0..n_words-1 serially (one digit per clock)
// and {pos, neg, count} per word lands in a result RAM read by the host.
// Build option: define CSD_SIGNED_EN for two's-complement operands
// (WIDTH digits, sign-extended lookahead, final carry dropped).
module csd_convert_array
  import csd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  csd_convert_array_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH + 2);
  localparam int IW = $clog2(WIDTH + 2);
  localparam int RW = 2 * (WIDTH + 1) + CW;
`ifdef CSD_SIGNED_EN
  localparam int ND = WIDTH;
`else
  localparam int ND = WIDTH + 1;
`endif

  logic [WIDTH-1:0] op_ram  [DEPTH];
  logic [RW-1:0]    res_ram [DEPTH];

  state_e           state_q, state_d;
  logic [AW:0]      w_q, w_d, n_q, n_d;
  logic [IW-1:0]    i_q, i_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH:0]   pos_q, pos_d, neg_q, neg_d;
  logic [WIDTH:0]   rd_pos_q, rd_pos_d, rd_neg_q, rd_neg_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [RW-1:0]    rd_word;

  logic             busy;
  logic             op_we;
  logic             res_we;
  logic             fill;
  logic [WIDTH+1:0] ext;
  logic             b_i, b_nx;
  digit_t           dig;
  logic             c_nx;

  // Bits above the operand read as zero, or as the sign bit in signed mode.
`ifdef CSD_SIGNED_EN
  assign fill = op_q[WIDTH-1];
`else
  assign fill = 1'b0;
`endif
  assign ext  = {{2{fill}}, op_q};
  assign b_i  = ext[i_q];
  assign b_nx = ext[i_q + IW'(1)];

  csd_recode_step u_step (
    .b_i    (b_i),
    .b_next (b_nx),
    .c_in   (c_q),
    .d      (dig),
    .c_out  (c_nx)
  );

  assign busy  = (state_q == LOAD) || (state_q == CONV) || (state_q == STORE);
  assign op_we = bus.we_in && !busy;

  // FSM next state and serial conversion datapath
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    n_d     = n_q;
    i_d     = i_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    res_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d     = bus.n_words;
          w_d     = '0;
          state_d = (bus.n_words == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        op_d    = op_ram[w_q[AW-1:0]];
        i_d     = '0;
        c_d     = 1'b0;
        cnt_d   = '0;
        pos_d   = '0;
        neg_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        c_d   = c_nx;
        cnt_d = cnt_q + CW'(dig != DIG_ZERO);
        for (int k = 0; k <= WIDTH; k++) begin
          if (i_q == IW'(k)) begin
            pos_d[k] = (dig == DIG_POS);
            neg_d[k] = (dig == DIG_NEG);
          end
        end
        i_d = i_q + IW'(1);
        if (i_q == IW'(ND - 1)) state_d = STORE;
      end
      STORE: begin
        res_we  = 1'b1;
        w_d     = w_q + {{AW{1'b0}}, 1'b1};
        state_d = (w_d == n_q) ? DONE : LOAD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers; reset aborts a batch immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      w_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      n_q     <= n_d;
      i_q     <= i_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

  // Operand RAM write port, frozen while a batch runs; contents survive reset
  always_ff @(posedge clk) begin
    if (op_we) op_ram[bus.addr_in] <= bus.data_in;
  end

  // Result RAM write port, one word per STORE
  always_ff @(posedge clk) begin
    if (res_we) res_ram[w_q[AW-1:0]] <= {pos_q, neg_q, cnt_q};
  end

  // Result read port decode; a same-cycle STORE to this address is not forwarded
  always_comb begin
    rd_word  = res_ram[bus.rd_addr];
    rd_pos_d = rd_word[RW-1 -: WIDTH+1];
    rd_neg_d = rd_word[CW +: WIDTH+1];
    rd_cnt_d = rd_word[CW-1:0];
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pos_q <= '0;
      rd_neg_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      rd_pos_q <= rd_pos_d;
      rd_neg_q <= rd_neg_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign bus.rd_pos = rd_pos_q;
  assign bus.rd_neg = rd_neg_q;
  assign bus.rd_cnt = rd_cnt_q;
  assign bus.busy   = busy;
  assign bus.done   = (state_q == DONE);

endmodule

// File: tb/tb_csd_convert_array.sv
// Directed bench for csd_convert_array: reads are pushed to a scoreboard and
// checked by an independent monitor; batch timing is checked inline.
module tb_csd_convert_array;
  localparam int W = 8;
  localparam int D = 16;
`ifdef CSD_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 3;
`endif

  typedef struct {
    bit         prop;
    int         addr;
    logic [8:0] pos;
    logic [8:0] neg;
    logic [3:0] cnt;
    logic [7:0] op;
  } exp_t;

  logic clk;
  logic reset;
  bit   rd_issue;
  int   n_vec;
  int   n_err;
  exp_t sb[$];

  csd_convert_array_if #(.WIDTH(W), .DEPTH(D)) bus ();

  csd_convert_array #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Independent value check: digits must reconstruct the operand and be canonical.
  function automatic bit prop_ok(input logic [7:0] op, input logic [8:0] p,
                                 input logic [8:0] n, input logic [3:0] c);
    int v, want, pc;
    logic [8:0] nz;
    v = int'(p) - int'(n);
`ifdef CSD_SIGNED_EN
    want = int'($signed(op));
    if (p[8] || n[8]) return 1'b0;
`else
    want = int'(op);
`endif
    nz = p | n;
    pc = $countones(nz);
    return (v == want) && ((p & n) == 9'd0) && ((nz & (nz >> 1)) == 9'd0) && (pc == int'(c));
  endfunction

  // Scoreboard monitor: every issued read is compared one cycle later.
  always @(posedge clk) begin
    exp_t e;
    if (rd_issue) begin
      #1;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: no expected entry queued");
      end else begin
        e = sb.pop_front();
        if (!e.prop) begin
          if (bus.rd_pos !== e.pos || bus.rd_neg !== e.neg || bus.rd_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL rd[%0d]: got pos=%h neg=%h cnt=%0d want pos=%h neg=%h cnt=%0d",
                     e.addr, bus.rd_pos, bus.rd_neg, bus.rd_cnt, e.pos, e.neg, e.cnt);
          end
        end else if (!prop_ok(e.op, bus.rd_pos, bus.rd_neg, bus.rd_cnt)) begin
          n_err++;
          $display("FAIL rd_prop[%0d] op=%h: got pos=%h neg=%h cnt=%0d, want a canonical CSD of op",
                   e.addr, e.op, bus.rd_pos, bus.rd_neg, bus.rd_cnt);
        end
      end
    end
  end

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    bus.we_in   = 1'b1;
    bus.addr_in = a[3:0];
    bus.data_in = d;
    @(negedge clk);
    bus.we_in   = 1'b0;
  endtask

  task automatic rd_exp(input int a, input bit prop, input logic [8:0] p,
                        input logic [8:0] n, input logic [3:0] c, input logic [7:0] op);
    exp_t e;
    @(negedge clk);
    bus.rd_addr = a[3:0];
    e.prop = prop; e.addr = a; e.pos = p; e.neg = n; e.cnt = c; e.op = op;
    sb.push_back(e);
    rd_issue = 1'b1;
  endtask

  task automatic rd_stop();
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  // Start a batch; optionally disturb it at cycle dist_at or reset it at cycle rst_at.
  task automatic run_batch(input int n, input int dist_at, input int rst_at);
    int cyc;
    @(negedge clk);
    bus.n_words = n[4:0];
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(bus.busy), 32'(n != 0));
    while (cyc < 2000) begin
      if (bus.done) break;
      if (cyc == dist_at) begin
        bus.start   = 1'b1;
        bus.n_words = 5'd1;
        bus.we_in   = 1'b1;
        bus.addr_in = 4'd1;
        bus.data_in = 8'h00;
      end else begin
        bus.start = 1'b0;
        bus.we_in = 1'b0;
      end
      if (cyc == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rd",   {bus.rd_cnt, bus.rd_neg, bus.rd_pos}, 32'd0);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_cycle", cyc, n * LAT + 1);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
  endtask

  logic [7:0] ops1 [4] = '{8'h07, 8'hFF, 8'h55, 8'h1B};
  logic [8:0] pos1 [4];
  logic [8:0] neg1 [4];
  logic [3:0] cnt1 [4];
  logic [7:0] ops6 [16] = '{8'h01, 8'h02, 8'h03, 8'h0F, 8'h33, 8'h5A, 8'h6D, 8'h7F,
                            8'h80, 8'h81, 8'hAA, 8'hB7, 8'hC3, 8'hE9, 8'hFE, 8'hF0};
  logic [8:0] pos80, neg80;

  initial begin
    n_vec = 0; n_err = 0; rd_issue = 1'b0;
`ifdef CSD_SIGNED_EN
    pos1 = '{9'h008, 9'h000, 9'h055, 9'h020};
    neg1 = '{9'h001, 9'h001, 9'h000, 9'h005};
    cnt1 = '{4'd2, 4'd1, 4'd4, 4'd3};
    pos80 = 9'h000; neg80 = 9'h080;
`else
    pos1 = '{9'h008, 9'h100, 9'h055, 9'h020};
    neg1 = '{9'h001, 9'h001, 9'h000, 9'h005};
    cnt1 = '{4'd2, 4'd2, 4'd4, 4'd3};
    pos80 = 9'h080; neg80 = 9'h000;
`endif
    reset = 1'b1;
    bus.we_in = 1'b0; bus.addr_in = '0; bus.data_in = '0;
    bus.start = 1'b0; bus.n_words = '0; bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_rd",   {bus.rd_cnt, bus.rd_neg, bus.rd_pos}, 32'd0);
    reset = 1'b0;

    // Basic batch of four words
    for (int k = 0; k < 4; k++) wr(k, ops1[k]);
    run_batch(4, 0, 0);
    for (int k = 0; k < 4; k++) rd_exp(k, 1'b0, pos1[k], neg1[k], cnt1[k], ops1[k]);
    rd_stop();

    // Zero operand, most-negative / MSB-only operand, then an empty batch
    wr(0, 8'h00);
    wr(1, 8'h80);
    run_batch(2, 0, 0);
    rd_exp(0, 1'b0, 9'h000, 9'h000, 4'd0, 8'h00);
    rd_exp(1, 1'b0, pos80, neg80, 4'd1, 8'h80);
    rd_stop();
    run_batch(0, 0, 0);
    rd_exp(0, 1'b0, 9'h000, 9'h000, 4'd0, 8'h00);
    rd_stop();

    // start and we_in pulsed mid-batch must be ignored
    wr(0, ops1[0]);
    wr(1, ops1[1]);
    run_batch(4, 15, 0);
    for (int k = 0; k < 4; k++) rd_exp(k, 1'b0, pos1[k], neg1[k], cnt1[k], ops1[k]);
    rd_stop();

    // Clear results, then reset during CONV of word 2
    for (int k = 0; k < 4; k++) wr(k, 8'h00);
    run_batch(4, 0, 0);
    for (int k = 0; k < 4; k++) wr(k, ops1[k]);
    run_batch(4, 0, 2 * LAT + 5);
    rd_exp(0, 1'b0, pos1[0], neg1[0], cnt1[0], ops1[0]);
    rd_exp(1, 1'b0, pos1[1], neg1[1], cnt1[1], ops1[1]);
    rd_exp(2, 1'b0, 9'h000, 9'h000, 4'd0, 8'h00);
    rd_stop();
    run_batch(4, 0, 0);
    for (int k = 0; k < 4; k++) rd_exp(k, 1'b0, pos1[k], neg1[k], cnt1[k], ops1[k]);
    rd_stop();

    // Full-depth batch checked against arithmetic value and canonical form
    for (int k = 0; k < 16; k++) wr(k, ops6[k]);
    run_batch(16, 0, 0);
    for (int k = 0; k < 16; k++) rd_exp(k, 1'b1, 9'h0, 9'h0, 4'd0, ops6[k]);
    rd_stop();

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
